axi_wr_burst_splitter: RTL and testbench
========================================

# axi_wr_burst_splitter

AXI4 write-path burst splitter placed directly downstream of the width adapter's master port, ahead of slave ports that accept limited burst lengths. Each accepted INCR write burst is cut into sub-bursts of at most `MAX_BURST_LEN` beats, optionally also at 4 KB boundaries. The block regenerates `wlast` for each sub-burst, merges the sub-burst B responses, and returns exactly one B response per original burst. One original burst is in flight at a time.

## Interface
- `ADDR_WIDTH`, 32, address width (>=12)
- `DATA_WIDTH`, 32, W data width; `STRB_WIDTH` = `DATA_WIDTH/8`
- `ID_WIDTH`, 8, ID width
- `MAX_BURST_LEN`, 16, maximum beats per downstream burst (1..256)
- `clk`  in  1  clock; the block uses one clock
- `rst`  in  1  reset, synchronous and active-high
- `s_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awregion`  in  ID/ADDR/8/3/2/1/4/3/4/4  upstream AW
- `s_axi_awvalid`  in  1 / `s_axi_awready`  out  1
- `s_axi_wdata/wstrb/wlast`  in  DATA/STRB/1; `s_axi_wvalid` in 1; `s_axi_wready` out 1
- `s_axi_bid/bresp`  out  ID/2; `s_axi_bvalid` out 1; `s_axi_bready` in 1
- `m_axi_aw*`  out  same widths as `s_axi_aw*`; `m_axi_awvalid` out 1; `m_axi_awready` in 1
- `m_axi_wdata/wstrb/wlast/wvalid`  out  DATA/STRB/1/1; `m_axi_wready` in 1
- `m_axi_bid/bresp/bvalid`  in  ID/2/1; `m_axi_bready` out 1

## Operation
- FSM states: IDLE, AW, W, BWAIT, BOUT.
- IDLE:
  - `s_axi_awready`=1.
  - On handshake: latch all AW fields and set `rem` = awlen+1 (9 bits), `cur_addr` = awaddr, `nsub` = 0, `bcnt` = 0, `acc_resp` = 0. Go to AW.
- AW:
  - Sub-length `sl` = min(`rem`, `MAX_BURST_LEN`, `b4k`), where `b4k` = (4096 - cur_addr[11:0]) >> awsize.
  - FIXED and WRAP bursts are never split: `sl` = `rem`, with `rem` <= 16 per the AXI4 protocol.
  - Drive `m_axi_awaddr`=`cur_addr` and `m_axi_awlen`=`sl`-1. All other fields are forwarded unchanged, including the ID.
  - On handshake: `nsub`++, `beat` = `sl`-1, go to W.
- W:
  - Pass-through: `m_axi_wvalid`=`s_axi_wvalid` and `s_axi_wready`=`m_axi_wready`. Data and strobe are passed unchanged.
  - `m_axi_wlast` = (`beat`==0). `s_axi_wlast` is ignored.
  - Each beat handshake decrements `beat` and `rem`.
  - On the last beat: for INCR, `cur_addr` += `sl`<<awsize. If `rem` is then 0, go to BWAIT; otherwise go to AW.
- B channel:
  - `m_axi_bready`=1 in AW, W and BWAIT; 0 in IDLE and BOUT.
  - Each m_B handshake: `bcnt`++, `acc_resp` = max(`acc_resp`, `m_axi_bresp`) by numeric code, so DECERR > SLVERR > EXOKAY > OKAY.
- BWAIT: when `bcnt`==`nsub` (counting any handshake in the same cycle), go to BOUT.
- BOUT:
  - `s_axi_bvalid`=1, `s_axi_bid`=latched ID, `s_axi_bresp`=`acc_resp`.
  - On `s_axi_bready`, go to IDLE.
- `bcnt` and `nsub` are 9 bits; a 256-beat burst can produce at most 256 sub-bursts when `MAX_BURST_LEN`=1.

## Timing
- Reset values: all `*valid` outputs 0, `s_axi_awready`=0 during reset and 1 in the first cycle after reset, `m_axi_bready`=0, all data outputs 0, FSM in IDLE.
- A reset asserted mid-burst abandons the burst immediately. No partial B response is issued.
- `m_axi_aw*` outputs are registered:
  - `m_axi_awvalid` rises the cycle after the s_AW handshake (1-cycle latency).
  - It rises the cycle after the final beat of the previous sub-burst when re-entering AW.
- The W path is combinational: zero added latency and no data buffering. W beats presented before the corresponding AW issues are stalled (`s_axi_wready`=0).
- Once asserted, `m_axi_awvalid` and its payload hold stable until `m_axi_awready`.
- `s_axi_bvalid` rises the cycle after the last sub-burst B handshake and holds until `s_axi_bready`.
- Min per-burst overhead: 1 (accept) + 1 per sub-burst AW + 1 (BOUT).

## Configuration
- `AXI_SPLIT_4K_EN` defined: the `b4k` term is included in `sl`, so no downstream INCR burst crosses a 4 KB boundary.
- Undefined: `sl` = min(`rem`, `MAX_BURST_LEN`); splits occur only on length.

## Test plan
- INCR, awaddr=0x1000, awlen=39, size=2, `MAX_BURST_LEN`=16 -> three m_AW bursts: 0x1000 len15, 0x1040 len15, 0x1080 len7. `m_axi_wlast` is asserted on beats 16, 32 and 40. One s_B with OKAY.
- With `AXI_SPLIT_4K_EN`: INCR, awaddr=0x0FF8, awlen=3, size=2 -> 0x0FF8 len1 and 0x1000 len1. Without the macro -> a single burst, 0x0FF8 len3.
- Three sub-bursts returning bresp OKAY, SLVERR, OKAY -> one s_B with bresp=SLVERR and the original ID, presented only after the third m_B.
- WRAP, awlen=7, `MAX_BURST_LEN`=4 -> a single m_AW with len7 and burst=WRAP. Addresses are unchanged.
- Hold `m_axi_awready`=0 for 5 cycles, then toggle `m_axi_wready` randomly -> `m_axi_awvalid` and its payload remain stable. W data and ordering match the input with no dropped or duplicated beats.
- Assert `rst` in the W state mid-burst -> the next cycle shows all valids 0 and the FSM in IDLE. A new burst then completes normally.

Source files
------------

// File: rtl/axi_wr_burst_splitter.sv
// AXI4 write burst splitter: cuts INCR bursts into sub-bursts of at most MAX_BURST_LEN beats and
// merges their B responses into one. Define AXI_SPLIT_4K_EN to also split at 4 KB boundaries.
module axi_wr_burst_splitter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int MAX_BURST_LEN = 16,
    localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic [3:0]            s_axi_awregion,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic [3:0]            m_axi_awregion,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);
    typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_BWAIT, ST_BOUT} state_t;

    localparam logic [8:0] MAX_LEN    = 9'(MAX_BURST_LEN);
    localparam logic [1:0] BURST_INCR = 2'b01;
`ifdef AXI_SPLIT_4K_EN
    localparam bit SPLIT_4K = 1'b1;
`else
    localparam bit SPLIT_4K = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [8:0]            rem_q, rem_d;
    logic [8:0]            nsub_q, nsub_d;
    logic [8:0]            bcnt_q, bcnt_d;
    logic [7:0]            beat_q, beat_d;
    logic [1:0]            acc_resp_q, acc_resp_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic                  awvalid_q, awvalid_d;
    logic [ID_WIDTH-1:0]   awid_q, awid_d;
    logic [7:0]            awlen_q, awlen_d;
    logic [2:0]            awsize_q, awsize_d;
    logic [1:0]            awburst_q, awburst_d;
    logic                  awlock_q, awlock_d;
    logic [3:0]            awcache_q, awcache_d;
    logic [2:0]            awprot_q, awprot_d;
    logic [3:0]            awqos_q, awqos_d;
    logic [3:0]            awregion_q, awregion_d;
    logic [8:0]            sl_cur, sl_next;
    logic                  in_w, w_hs, b_hs, unused_inputs;

    function automatic logic [8:0] sub_len(input logic [8:0] rem, input logic [11:0] addr_lo,
                                           input logic [2:0] size, input logic [1:0] burst);
        logic [12:0] b4k;
        logic [8:0]  sl;
        sl  = rem;
        b4k = (13'd4096 - {1'b0, addr_lo}) >> size;
        // A start address inside the final partial beat of a page must still move one beat.
        if (b4k == 13'd0) b4k = 13'd1;
        if (burst == BURST_INCR) begin
            if (sl > MAX_LEN) sl = MAX_LEN;
            if (SPLIT_4K && ({4'd0, sl} > b4k)) sl = b4k[8:0];
        end
        return sl;
    endfunction

    assign sl_cur        = {1'b0, awlen_q} + 9'd1;
    assign in_w          = (state_q == ST_W);
    assign w_hs          = in_w && s_axi_wvalid && m_axi_wready;
    assign b_hs          = m_axi_bvalid && m_axi_bready;
    assign unused_inputs = ^{s_axi_wlast, m_axi_bid};

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        nsub_d     = nsub_q;
        bcnt_d     = bcnt_q;
        beat_d     = beat_q;
        acc_resp_d = acc_resp_q;
        cur_addr_d = cur_addr_q;
        awvalid_d  = awvalid_q;
        awid_d     = awid_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        awburst_d  = awburst_q;
        awlock_d   = awlock_q;
        awcache_d  = awcache_q;
        awprot_d   = awprot_q;
        awqos_d    = awqos_q;
        awregion_d = awregion_q;
        sl_next    = 9'd0;
        // Response codes are ordered by severity, so the merged response is a numeric max.
        if (b_hs) begin
            bcnt_d = bcnt_q + 9'd1;
            if (m_axi_bresp > acc_resp_q) acc_resp_d = m_axi_bresp;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (s_axi_awvalid) begin
                    awid_d     = s_axi_awid;
                    awsize_d   = s_axi_awsize;
                    awburst_d  = s_axi_awburst;
                    awlock_d   = s_axi_awlock;
                    awcache_d  = s_axi_awcache;
                    awprot_d   = s_axi_awprot;
                    awqos_d    = s_axi_awqos;
                    awregion_d = s_axi_awregion;
                    rem_d      = {1'b0, s_axi_awlen} + 9'd1;
                    cur_addr_d = s_axi_awaddr;
                    nsub_d     = 9'd0;
                    bcnt_d     = 9'd0;
                    acc_resp_d = 2'b00;
                    sl_next    = sub_len(rem_d, s_axi_awaddr[11:0], s_axi_awsize, s_axi_awburst);
                    awlen_d    = sl_next[7:0] - 8'd1;
                    awvalid_d  = 1'b1;
                    state_d    = ST_AW;
                end
            end
            ST_AW: begin
                if (m_axi_awready) begin
                    awvalid_d = 1'b0;
                    nsub_d    = nsub_q + 9'd1;
                    beat_d    = awlen_q;
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                if (w_hs) begin
                    rem_d  = rem_q - 9'd1;
                    beat_d = beat_q - 8'd1;
                    if (beat_q == 8'd0) begin
                        if (awburst_q == BURST_INCR)
                            cur_addr_d = cur_addr_q + (ADDR_WIDTH'(sl_cur) << awsize_q);
                        if (rem_q == 9'd1) begin
                            state_d = ST_BWAIT;
                        end else begin
                            sl_next   = sub_len(rem_d, cur_addr_d[11:0], awsize_q, awburst_q);
                            awlen_d   = sl_next[7:0] - 8'd1;
                            awvalid_d = 1'b1;
                            state_d   = ST_AW;
                        end
                    end
                end
            end
            ST_BWAIT: begin
                if (bcnt_d == nsub_q) state_d = ST_BOUT;
            end
            ST_BOUT: begin
                if (s_axi_bready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            nsub_q     <= '0;
            bcnt_q     <= '0;
            beat_q     <= '0;
            acc_resp_q <= '0;
            cur_addr_q <= '0;
            awvalid_q  <= 1'b0;
            awid_q     <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            awburst_q  <= '0;
            awlock_q   <= 1'b0;
            awcache_q  <= '0;
            awprot_q   <= '0;
            awqos_q    <= '0;
            awregion_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            nsub_q     <= nsub_d;
            bcnt_q     <= bcnt_d;
            beat_q     <= beat_d;
            acc_resp_q <= acc_resp_d;
            cur_addr_q <= cur_addr_d;
            awvalid_q  <= awvalid_d;
            awid_q     <= awid_d;
            awlen_q    <= awlen_d;
            awsize_q   <= awsize_d;
            awburst_q  <= awburst_d;
            awlock_q   <= awlock_d;
            awcache_q  <= awcache_d;
            awprot_q   <= awprot_d;
            awqos_q    <= awqos_d;
            awregion_q <= awregion_d;
        end
    end

    assign s_axi_awready  = (state_q == ST_IDLE) && !rst;
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_awid     = awid_q;
    assign m_axi_awaddr   = cur_addr_q;
    assign m_axi_awlen    = awlen_q;
    assign m_axi_awsize   = awsize_q;
    assign m_axi_awburst  = awburst_q;
    assign m_axi_awlock   = awlock_q;
    assign m_axi_awcache  = awcache_q;
    assign m_axi_awprot   = awprot_q;
    assign m_axi_awqos    = awqos_q;
    assign m_axi_awregion = awregion_q;
    assign m_axi_wvalid   = in_w && s_axi_wvalid;
    assign s_axi_wready   = in_w && m_axi_wready;
    assign m_axi_wdata    = in_w ? s_axi_wdata : '0;
    assign m_axi_wstrb    = in_w ? s_axi_wstrb : '0;
    assign m_axi_wlast    = in_w && (beat_q == 8'd0);
    assign m_axi_bready   = (state_q == ST_AW) || in_w || (state_q == ST_BWAIT);
    assign s_axi_bvalid   = (state_q == ST_BOUT);
    assign s_axi_bid      = (state_q == ST_BOUT) ? awid_q : '0;
    assign s_axi_bresp    = (state_q == ST_BOUT) ? acc_resp_q : 2'b00;
endmodule

// File: tb/tb_axi_wr_burst_splitter.sv
// Bench for axi_wr_burst_splitter (MAX_BURST_LEN=4): vector table, reset corner cases and random
// bursts checked against a transaction-level split model. Honours AXI_SPLIT_4K_EN.
module tb_axi_wr_burst_splitter;
    localparam int TB_MAX = 4;

    logic        clk, rst;
    logic [7:0]  s_axi_awid, s_axi_awlen, m_axi_awid, m_axi_awlen, s_axi_bid, m_axi_bid;
    logic [31:0] s_axi_awaddr, m_axi_awaddr, s_axi_wdata, m_axi_wdata;
    logic [2:0]  s_axi_awsize, s_axi_awprot, m_axi_awsize, m_axi_awprot;
    logic [1:0]  s_axi_awburst, m_axi_awburst, s_axi_bresp, m_axi_bresp;
    logic        s_axi_awlock, m_axi_awlock;
    logic [3:0]  s_axi_awcache, s_axi_awqos, s_axi_awregion, s_axi_wstrb;
    logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_awregion, m_axi_wstrb;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready, m_axi_awvalid, m_axi_awready;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;

    axi_wr_burst_splitter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8),
                            .MAX_BURST_LEN(TB_MAX)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awregion(s_axi_awregion), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } sub_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  id;
        logic [1:0]  r0, r1, r2;
        int          exp_nsub;
        logic [31:0] exp_a0;
        logic [7:0]  exp_l0;
        logic [31:0] exp_al;
        logic [7:0]  exp_ll;
        logic [1:0]  exp_bresp;
    } vec_t;

    int         n_checks = 0;
    int         n_pass = 0;
    sub_t       exp_aw[$];
    sub_t       obs_aw[$];
    logic [1:0] bresp_pat[$];
    logic [7:0] last_bid;
    logic [1:0] last_bresp;
    vec_t       vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [1:0] pat(input int i);
        if (i < bresp_pat.size()) return bresp_pat[i];
        return 2'b00;
    endfunction

    // Reference split: walk the burst with plain arithmetic, emitting one sub-burst per step.
    function automatic void model_split(input logic [31:0] addr, input int len, input int size,
                                        input logic [1:0] burst);
        logic [31:0] a;
        int rem, sl, b;
        a   = addr;
        rem = len + 1;
        exp_aw.delete();
        while (rem > 0) begin
            if (burst == 2'b01) begin
                sl = (rem < TB_MAX) ? rem : TB_MAX;
`ifdef AXI_SPLIT_4K_EN
                b = (4096 - int'(a[11:0])) >> size;
                if (b < 1) b = 1;
                if (b < sl) sl = b;
`endif
            end else begin
                sl = rem;
            end
            exp_aw.push_back('{addr: a, len: 8'(sl - 1)});
            rem -= sl;
            if (burst == 2'b01) a = a + 32'(sl << size);
        end
    endfunction

    task automatic idle_inputs();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [7:0] id, input int hold,
                             input int wr_pct);
        logic [31:0] wdat[$];
        logic [3:0]  wstb[$];
        logic [31:0] got_data[$];
        logic [3:0]  got_strb[$];
        bit          got_last[$];
        bit          exp_last[$];
        int          w_idx, b_idx, n_last, cyc, aw_wait, stab_err, early_b, fwd_err, data_err, last_err;
        bit          aw_pend, done, hold_cap;
        logic [31:0] pa;
        logic [7:0]  pl;
        logic [1:0]  exp_resp;
        logic        lock;
        logic [3:0]  cache, qos, region;
        logic [2:0]  prot;
        w_idx = 0; b_idx = 0; n_last = 0; cyc = 0; aw_wait = 0; stab_err = 0; early_b = 0;
        fwd_err = 0; data_err = 0; last_err = 0; aw_pend = 1; done = 0; hold_cap = 0;
        pa = '0; pl = '0;
        lock = 1'($urandom); cache = 4'($urandom); qos = 4'($urandom);
        region = 4'($urandom); prot = 3'($urandom);
        obs_aw.delete();
        model_split(addr, int'(len), int'(size), burst);
        for (int i = 0; i <= int'(len); i++) begin
            wdat.push_back($urandom);
            wstb.push_back(4'($urandom));
        end
        exp_resp = 2'b00;
        foreach (exp_aw[i]) begin
            if (pat(i) > exp_resp) exp_resp = pat(i);
            for (int k = 0; k <= int'(exp_aw[i].len); k++) exp_last.push_back(k == int'(exp_aw[i].len));
        end
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            s_axi_awvalid = aw_pend; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
            s_axi_awburst = burst; s_axi_awid = id; s_axi_awlock = lock; s_axi_awcache = cache;
            s_axi_awprot = prot; s_axi_awqos = qos; s_axi_awregion = region;
            s_axi_wvalid = (w_idx <= int'(len)) && ($urandom_range(0, 99) < 80);
            s_axi_wdata  = (w_idx <= int'(len)) ? wdat[w_idx] : 32'd0;
            s_axi_wstrb  = (w_idx <= int'(len)) ? wstb[w_idx] : 4'd0;
            s_axi_wlast  = (w_idx == int'(len));
            m_axi_awready = (aw_wait >= hold) && ($urandom_range(0, 99) < 70);
            m_axi_wready  = ($urandom_range(0, 99) < wr_pct);
            m_axi_bvalid  = (b_idx < n_last);
            m_axi_bresp   = pat(b_idx);
            m_axi_bid     = id;
            s_axi_bready  = 1'($urandom_range(0, 1));
            #1;
            if (hold_cap && (!m_axi_awvalid || m_axi_awaddr !== pa || m_axi_awlen !== pl)) stab_err++;
            hold_cap = 0;
            if (s_axi_awvalid && s_axi_awready) aw_pend = 0;
            if (m_axi_awvalid) begin
                if (m_axi_awready) begin
                    obs_aw.push_back('{addr: m_axi_awaddr, len: m_axi_awlen});
                    if (m_axi_awid !== id || m_axi_awsize !== size || m_axi_awburst !== burst ||
                        m_axi_awlock !== lock || m_axi_awcache !== cache || m_axi_awprot !== prot ||
                        m_axi_awqos !== qos || m_axi_awregion !== region) fwd_err++;
                    aw_wait = 0;
                end else begin
                    aw_wait++;
                    hold_cap = 1;
                    pa = m_axi_awaddr;
                    pl = m_axi_awlen;
                end
            end
            if (s_axi_wvalid && s_axi_wready) w_idx++;
            if (m_axi_wvalid && m_axi_wready) begin
                got_data.push_back(m_axi_wdata);
                got_strb.push_back(m_axi_wstrb);
                got_last.push_back(m_axi_wlast);
                if (m_axi_wlast) n_last++;
            end
            if (m_axi_bvalid && m_axi_bready) b_idx++;
            if (s_axi_bvalid) begin
                if (b_idx != exp_aw.size()) early_b++;
                if (s_axi_bready) begin
                    last_bid = s_axi_bid;
                    last_bresp = s_axi_bresp;
                    done = 1;
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        check("burst_done", 64'(done), 64'd1);
        check("n_sub", 64'(obs_aw.size()), 64'(exp_aw.size()));
        for (int i = 0; i < obs_aw.size() && i < exp_aw.size(); i++) begin
            check("sub_addr", 64'(obs_aw[i].addr), 64'(exp_aw[i].addr));
            check("sub_len", 64'(obs_aw[i].len), 64'(exp_aw[i].len));
        end
        check("n_beats", 64'(got_data.size()), 64'(int'(len) + 1));
        for (int i = 0; i < got_data.size() && i <= int'(len); i++) begin
            if (got_data[i] !== wdat[i] || got_strb[i] !== wstb[i]) data_err++;
            if (got_last[i] !== exp_last[i]) last_err++;
        end
        check("w_data_errs", 64'(data_err), 64'd0);
        check("wlast_errs", 64'(last_err), 64'd0);
        check("aw_fwd_errs", 64'(fwd_err), 64'd0);
        check("aw_stable_errs", 64'(stab_err), 64'd0);
        check("early_s_b", 64'(early_b), 64'd0);
        check("s_bid", 64'(last_bid), 64'(id));
        check("s_bresp", 64'(last_bresp), 64'(exp_resp));
        $display("burst addr=%08h len=%0d size=%0d burst=%0d id=%02h subs=%0d bresp=%0d cycles=%0d",
                 addr, len, size, burst, id, obs_aw.size(), last_bresp, cyc);
    endtask

    initial begin
        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0;
        s_axi_awregion = '0; s_axi_wdata = '0; s_axi_wstrb = '0; m_axi_bid = '0;
        last_bid = '0; last_bresp = '0;
        idle_inputs();

        vecs[0] = '{32'h1000, 8'd39, 3'd2, 2'd1, 8'h11, 2'd0, 2'd0, 2'd0, 10, 32'h1000, 8'd3, 32'h1090, 8'd3, 2'd0};
        vecs[2] = '{32'h2000, 8'd11, 3'd2, 2'd1, 8'h5A, 2'd0, 2'd2, 2'd0, 3, 32'h2000, 8'd3, 32'h2020, 8'd3, 2'd2};
        vecs[3] = '{32'h3010, 8'd7, 3'd2, 2'd2, 8'h33, 2'd1, 2'd0, 2'd0, 1, 32'h3010, 8'd7, 32'h3010, 8'd7, 2'd1};
        vecs[4] = '{32'h4004, 8'd0, 3'd0, 2'd1, 8'hFF, 2'd3, 2'd0, 2'd0, 1, 32'h4004, 8'd0, 32'h4004, 8'd0, 2'd3};
        vecs[5] = '{32'h0000, 8'd255, 3'd2, 2'd1, 8'h01, 2'd1, 2'd0, 2'd3, 64, 32'h0000, 8'd3, 32'h03F0, 8'd3, 2'd3};
        vecs[6] = '{32'h5000, 8'd9, 3'd2, 2'd0, 8'h44, 2'd2, 2'd0, 2'd0, 1, 32'h5000, 8'd9, 32'h5000, 8'd9, 2'd2};
`ifdef AXI_SPLIT_4K_EN
        vecs[1] = '{32'h0FF8, 8'd3, 3'd2, 2'd1, 8'h22, 2'd0, 2'd1, 2'd0, 2, 32'h0FF8, 8'd1, 32'h1000, 8'd1, 2'd1};
        vecs[7] = '{32'h1FFE, 8'd5, 3'd0, 2'd1, 8'h77, 2'd0, 2'd0, 2'd0, 2, 32'h1FFE, 8'd1, 32'h2000, 8'd3, 2'd0};
`else
        vecs[1] = '{32'h0FF8, 8'd3, 3'd2, 2'd1, 8'h22, 2'd0, 2'd1, 2'd0, 1, 32'h0FF8, 8'd3, 32'h0FF8, 8'd3, 2'd0};
        vecs[7] = '{32'h1FFE, 8'd5, 3'd0, 2'd1, 8'h77, 2'd0, 2'd0, 2'd0, 2, 32'h1FFE, 8'd3, 32'h2002, 8'd1, 2'd0};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_s_awready", 64'(s_axi_awready), 64'd0);
        check("rst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("rst_m_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("rst_s_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("rst_m_bready", 64'(m_axi_bready), 64'd0);
        check("rst_m_awaddr", 64'(m_axi_awaddr), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_awready", 64'(s_axi_awready), 64'd1);

        foreach (vecs[v]) begin
            bresp_pat = '{vecs[v].r0, vecs[v].r1, vecs[v].r2};
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].id, 0, 70);
            check("vec_nsub", 64'(obs_aw.size()), 64'(vecs[v].exp_nsub));
            if (obs_aw.size() > 0) begin
                check("vec_addr0", 64'(obs_aw[0].addr), 64'(vecs[v].exp_a0));
                check("vec_len0", 64'(obs_aw[0].len), 64'(vecs[v].exp_l0));
                check("vec_addr_last", 64'(obs_aw[obs_aw.size()-1].addr), 64'(vecs[v].exp_al));
                check("vec_len_last", 64'(obs_aw[obs_aw.size()-1].len), 64'(vecs[v].exp_ll));
            end
            check("vec_bresp", 64'(last_bresp), 64'(vecs[v].exp_bresp));
        end

        // AW held off for 5 cycles per sub-burst with a sparse, random W ready.
        bresp_pat = '{2'd0};
        run_burst(32'h6000, 8'd15, 3'd2, 2'd1, 8'hA5, 5, 40);

        // Reset in the middle of a W sub-burst.
        @(negedge clk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h7000; s_axi_awlen = 8'd7; s_axi_awsize = 3'd2;
        s_axi_awburst = 2'd1; s_axi_awid = 8'h99;
        @(negedge clk);
        s_axi_awvalid = 1'b0; m_axi_awready = 1'b1;
        @(negedge clk);
        m_axi_awready = 1'b0; s_axi_wvalid = 1'b1; s_axi_wdata = 32'hDEADBEEF; m_axi_wready = 1'b1;
        #1;
        check("midrst_in_w", 64'(m_axi_wvalid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
        check("midrst_m_wvalid", 64'(m_axi_wvalid), 64'd0);
        check("midrst_s_wready", 64'(s_axi_wready), 64'd0);
        check("midrst_s_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("midrst_m_bready", 64'(m_axi_bready), 64'd0);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("midrst_idle_awready", 64'(s_axi_awready), 64'd1);
        bresp_pat = '{2'd0, 2'd2};
        run_burst(32'h7000, 8'd7, 3'd2, 2'd1, 8'h99, 0, 80);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] addr;
            logic [7:0]  len;
            logic [2:0]  size;
            logic [1:0]  bt;
            int          r;
            size = 3'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            bt = (r < 7) ? 2'd1 : ((r < 9) ? 2'd2 : 2'd0);
            if (bt == 2'd1) len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                              : 8'($urandom_range(0, 40));
            else if (bt == 2'd2) len = 8'((2 << $urandom_range(0, 3)) - 1);
            else len = 8'($urandom_range(0, 15));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
            addr = (addr >> size) << size;
            bresp_pat.delete();
            for (int k = 0; k < 8; k++) bresp_pat.push_back(2'($urandom));
            run_burst(addr, len, size, bt, 8'($urandom), $urandom_range(0, 3), $urandom_range(30, 100));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
